// File: rtl/basic_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : basic_axi4_lite_master
// Description : AXI4-Lite initiator. Converts single-beat user read/write
//               commands into AXI4-Lite transactions and returns read data
//               plus the response code. One transaction outstanding at a time.
// Ports       : i_ACLK / i_ARESET        clock, synchronous active-high reset
//               i_CMD_* / o_CMD_READY    user command (valid/ready handshake)
//               o_RSP_*                  one-cycle completion pulse + payload
//               o_M_AW* / i_S_AWREADY    write address channel
//               o_M_W*  / i_S_WREADY     write data channel
//               i_S_B*  / o_M_BREADY     write response channel
//               o_M_AR* / i_S_ARREADY    read address channel
//               i_S_R*  / o_M_RREADY     read data channel
// Revision    : 1.0 - initial release
// ============================================================================
module basic_axi4_lite_master #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic                  i_ACLK,
  input  logic                  i_ARESET,
  // user command
  input  logic                  i_CMD_VALID,
  output logic                  o_CMD_READY,
  input  logic                  i_CMD_WE,
  input  logic [ADDR_W-1:0]     i_CMD_ADDR,
  input  logic [DATA_W-1:0]     i_CMD_WDATA,
  input  logic [DATA_W/8-1:0]   i_CMD_WSTRB,
  // user response
  output logic                  o_RSP_VALID,
  output logic [DATA_W-1:0]     o_RSP_RDATA,
  output logic [1:0]            o_RSP_RESP,
  // write address channel
  output logic [ADDR_W-1:0]     o_M_AWADDR,
  output logic [2:0]            o_M_AWPROT,
  output logic                  o_M_AWVALID,
  input  logic                  i_S_AWREADY,
  // write data channel
  output logic [DATA_W-1:0]     o_M_WDATA,
  output logic [DATA_W/8-1:0]   o_M_WSTRB,
  output logic                  o_M_WVALID,
  input  logic                  i_S_WREADY,
  // write response channel
  input  logic [1:0]            i_S_BRESP,
  input  logic                  i_S_BVALID,
  output logic                  o_M_BREADY,
  // read address channel
  output logic [ADDR_W-1:0]     o_M_ARADDR,
  output logic [2:0]            o_M_ARPROT,
  output logic                  o_M_ARVALID,
  input  logic                  i_S_ARREADY,
  // read data channel
  input  logic [DATA_W-1:0]     i_S_RDATA,
  input  logic [1:0]            i_S_RRESP,
  input  logic                  i_S_RVALID,
  output logic                  o_M_RREADY
);

  localparam int c_STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [c_STRB_W-1:0]   r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_arvalid;
  logic                  r_bready;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  // A write channel counts as done if it already handshook earlier or
  // handshakes on this edge; AW and W may finish in either order.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !r_awvalid || i_S_AWREADY;
  assign w_w_done  = !r_wvalid  || i_S_WREADY;

  always_ff @(posedge i_ACLK) begin
    if (i_ARESET) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_CMD_VALID) begin
            r_addr  <= i_CMD_ADDR;
            r_wdata <= i_CMD_WDATA;
            r_wstrb <= i_CMD_WSTRB;
            if (i_CMD_WE) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RADDR;
            end
          end
        end
        S_WR: begin
          if (r_awvalid && i_S_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid  && i_S_WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (i_S_BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= i_S_BRESP;
            r_state     <= S_IDLE;
          end
        end
        S_RADDR: begin
          if (i_S_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (i_S_RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= i_S_RDATA;
            r_rsp_resp  <= i_S_RRESP;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ready is suppressed while reset is held so no command slips in.
  assign o_CMD_READY = (r_state == S_IDLE) && !i_ARESET;

  assign o_RSP_VALID = r_rsp_valid;
  assign o_RSP_RDATA = r_rsp_rdata;
  assign o_RSP_RESP  = r_rsp_resp;

  // One address register serves both AW and AR; only one is ever valid.
  assign o_M_AWADDR  = r_addr;
  assign o_M_AWPROT  = PROT;
  assign o_M_AWVALID = r_awvalid;
  assign o_M_WDATA   = r_wdata;
  assign o_M_WSTRB   = r_wstrb;
  assign o_M_WVALID  = r_wvalid;
  assign o_M_BREADY  = r_bready;
  assign o_M_ARADDR  = r_addr;
  assign o_M_ARPROT  = PROT;
  assign o_M_ARVALID = r_arvalid;
  assign o_M_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_basic_axi4_lite_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_basic_axi4_lite_master
// Description : Scoreboard bench for basic_axi4_lite_master with a
//               configurable-latency AXI4-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_basic_axi4_lite_master;

  logic        i_ACLK = 1'b0;
  logic        i_ARESET = 1'b1;
  logic        i_CMD_VALID = 1'b0;
  logic        o_CMD_READY;
  logic        i_CMD_WE = 1'b0;
  logic [31:0] i_CMD_ADDR = '0;
  logic [31:0] i_CMD_WDATA = '0;
  logic [3:0]  i_CMD_WSTRB = '0;
  logic        o_RSP_VALID;
  logic [31:0] o_RSP_RDATA;
  logic [1:0]  o_RSP_RESP;
  logic [31:0] o_M_AWADDR;
  logic [2:0]  o_M_AWPROT;
  logic        o_M_AWVALID;
  logic        i_S_AWREADY = 1'b0;
  logic [31:0] o_M_WDATA;
  logic [3:0]  o_M_WSTRB;
  logic        o_M_WVALID;
  logic        i_S_WREADY = 1'b0;
  logic [1:0]  i_S_BRESP = 2'b00;
  logic        i_S_BVALID = 1'b0;
  logic        o_M_BREADY;
  logic [31:0] o_M_ARADDR;
  logic [2:0]  o_M_ARPROT;
  logic        o_M_ARVALID;
  logic        i_S_ARREADY = 1'b0;
  logic [31:0] i_S_RDATA = '0;
  logic [1:0]  i_S_RRESP = 2'b00;
  logic        i_S_RVALID = 1'b0;
  logic        o_M_RREADY;

  basic_axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
    .i_ACLK(i_ACLK), .i_ARESET(i_ARESET),
    .i_CMD_VALID(i_CMD_VALID), .o_CMD_READY(o_CMD_READY), .i_CMD_WE(i_CMD_WE),
    .i_CMD_ADDR(i_CMD_ADDR), .i_CMD_WDATA(i_CMD_WDATA), .i_CMD_WSTRB(i_CMD_WSTRB),
    .o_RSP_VALID(o_RSP_VALID), .o_RSP_RDATA(o_RSP_RDATA), .o_RSP_RESP(o_RSP_RESP),
    .o_M_AWADDR(o_M_AWADDR), .o_M_AWPROT(o_M_AWPROT), .o_M_AWVALID(o_M_AWVALID),
    .i_S_AWREADY(i_S_AWREADY),
    .o_M_WDATA(o_M_WDATA), .o_M_WSTRB(o_M_WSTRB), .o_M_WVALID(o_M_WVALID),
    .i_S_WREADY(i_S_WREADY),
    .i_S_BRESP(i_S_BRESP), .i_S_BVALID(i_S_BVALID), .o_M_BREADY(o_M_BREADY),
    .o_M_ARADDR(o_M_ARADDR), .o_M_ARPROT(o_M_ARPROT), .o_M_ARVALID(o_M_ARVALID),
    .i_S_ARREADY(i_S_ARREADY),
    .i_S_RDATA(i_S_RDATA), .i_S_RRESP(i_S_RRESP), .i_S_RVALID(i_S_RVALID),
    .o_M_RREADY(o_M_RREADY)
  );

  always #5 i_ACLK = ~i_ACLK;

  int cyc = 0;
  always @(posedge i_ACLK) cyc <= cyc + 1;

  // ---------------- slave model configuration ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  bit          b_hold = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;

  // Slave model: everything changes on the falling edge; *_hs records a
  // handshake that will complete on the coming rising edge.
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit aw_seen = 0, w_seen = 0, ar_seen = 0;
  bit aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;

  always @(negedge i_ACLK) begin
    if (i_ARESET) begin
      i_S_AWREADY = 0; i_S_WREADY = 0; i_S_ARREADY = 0;
      i_S_BVALID = 0; i_S_RVALID = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0;
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
    end else begin
      if (aw_hs) aw_seen = 1;
      if (w_hs)  w_seen = 1;
      if (ar_hs) begin ar_seen = 1; r_cnt = 0; end
      if (b_hs)  i_S_BVALID = 0;
      if (r_hs)  i_S_RVALID = 0;

      if (o_M_AWVALID) begin i_S_AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
      else begin i_S_AWREADY = 0; aw_cnt = 0; end
      if (o_M_WVALID) begin i_S_WREADY = (w_cnt >= w_delay); w_cnt++; end
      else begin i_S_WREADY = 0; w_cnt = 0; end
      if (o_M_ARVALID) begin i_S_ARREADY = (ar_cnt >= ar_delay); ar_cnt++; end
      else begin i_S_ARREADY = 0; ar_cnt = 0; end

      if (aw_seen && w_seen && !i_S_BVALID && !b_hold) begin
        i_S_BVALID = 1; i_S_BRESP = cfg_bresp; aw_seen = 0; w_seen = 0;
      end
      if (ar_seen && !i_S_RVALID) begin
        if (r_cnt >= r_delay) begin
          i_S_RVALID = 1; i_S_RDATA = cfg_rdata; i_S_RRESP = cfg_rresp; ar_seen = 0;
        end else r_cnt++;
      end

      aw_hs = o_M_AWVALID && i_S_AWREADY;
      w_hs  = o_M_WVALID && i_S_WREADY;
      ar_hs = o_M_ARVALID && i_S_ARREADY;
      b_hs  = i_S_BVALID && o_M_BREADY;
      r_hs  = i_S_RVALID && o_M_RREADY;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        rsp_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] ar_q[$];
  logic [35:0] w_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    logic        p_awv, p_wv, p_arv, p_aw_hs, p_w_hs, p_ar_hs, p_rst;
    logic [31:0] p_awaddr, p_araddr, p_wdata;
    logic [3:0]  p_wstrb;
    exp_t        e;
    logic [31:0] a;
    logic [35:0] wd;
    p_awv = 0; p_wv = 0; p_arv = 0; p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0; p_rst = 1;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
    forever begin
      @(negedge i_ACLK); #1;
      if (!p_rst) begin
        if (p_awv && !p_aw_hs) begin
          check("awvalid_hold", 64'(o_M_AWVALID), 64'd1);
          check("awaddr_stable", 64'(o_M_AWADDR), 64'(p_awaddr));
        end
        if (p_aw_hs) check("awvalid_drop", 64'(o_M_AWVALID), 64'd0);
        if (p_wv && !p_w_hs) begin
          check("wvalid_hold", 64'(o_M_WVALID), 64'd1);
          check("wdata_stable", 64'({o_M_WSTRB, o_M_WDATA}), 64'({p_wstrb, p_wdata}));
        end
        if (p_w_hs) check("wvalid_drop", 64'(o_M_WVALID), 64'd0);
        if (p_arv && !p_ar_hs) begin
          check("arvalid_hold", 64'(o_M_ARVALID), 64'd1);
          check("araddr_stable", 64'(o_M_ARADDR), 64'(p_araddr));
        end
        if (p_ar_hs) check("arvalid_drop", 64'(o_M_ARVALID), 64'd0);
      end
      if (o_M_BREADY) check("bready_after_aw_w", 64'({o_M_AWVALID, o_M_WVALID}), 64'd0);
      if (o_M_RREADY) check("rready_after_ar", 64'(o_M_ARVALID), 64'd0);

      if (!i_ARESET) begin
        if (o_M_AWVALID && i_S_AWREADY) begin
          if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
          else begin
            a = aw_q.pop_front();
            check("awaddr", 64'(o_M_AWADDR), 64'(a));
            check("awprot", 64'(o_M_AWPROT), 64'd0);
          end
        end
        if (o_M_WVALID && i_S_WREADY) begin
          if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
          else begin
            wd = w_q.pop_front();
            check("wstrb_wdata", 64'({o_M_WSTRB, o_M_WDATA}), 64'(wd));
          end
        end
        if (o_M_ARVALID && i_S_ARREADY) begin
          if (ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
          else begin
            a = ar_q.pop_front();
            check("araddr", 64'(o_M_ARADDR), 64'(a));
            check("arprot", 64'(o_M_ARPROT), 64'd0);
          end
        end
      end

      if (o_RSP_VALID) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
        else begin
          e = rsp_q.pop_front();
          check("rsp_rdata", 64'(o_RSP_RDATA), 64'(e.rdata));
          check("rsp_resp", 64'(o_RSP_RESP), 64'(e.resp));
          if (e.lat > 0) check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end

      p_rst    = i_ARESET;
      p_awv    = o_M_AWVALID; p_aw_hs = o_M_AWVALID && i_S_AWREADY; p_awaddr = o_M_AWADDR;
      p_wv     = o_M_WVALID;  p_w_hs  = o_M_WVALID && i_S_WREADY;
      p_wdata  = o_M_WDATA;   p_wstrb = o_M_WSTRB;
      p_arv    = o_M_ARVALID; p_ar_hs = o_M_ARVALID && i_S_ARREADY; p_araddr = o_M_ARADDR;
    end
  endtask

  // Presents a command (starting on a falling edge) until it is accepted and
  // queues the expected channel payloads and response.
  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] e_rdata,
                       input logic [1:0] e_resp, input int lat, input bit expect_rsp,
                       input bit b2b);
    exp_t e;
    i_CMD_VALID = 1; i_CMD_WE = we; i_CMD_ADDR = addr;
    i_CMD_WDATA = wdata; i_CMD_WSTRB = wstrb;
    for (int k = 0; k < 50 && !o_CMD_READY; k++) @(negedge i_ACLK);
    if (!o_CMD_READY) check("cmd_accept_timeout", 64'd0, 64'd1);
    else begin
      if (b2b) check("b2b_accept_with_rsp", 64'(o_RSP_VALID), 64'd1);
      if (we) begin
        aw_q.push_back(addr);
        w_q.push_back({wstrb, wdata});
      end else ar_q.push_back(addr);
      if (expect_rsp) begin
        e.rdata = e_rdata; e.resp = e_resp; e.acc = cyc; e.lat = lat;
        rsp_q.push_back(e);
      end
    end
    @(negedge i_ACLK);
    // Junk on the command bus while not valid must be ignored.
    i_CMD_VALID = 0; i_CMD_WE = 1; i_CMD_ADDR = 32'hFFFF_FFFF;
    i_CMD_WDATA = 32'hFFFF_FFFF; i_CMD_WSTRB = 4'hF;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && rsp_q.size() != 0; k++) @(negedge i_ACLK);
    @(negedge i_ACLK); #2;
    check("rsp_drain", 64'(rsp_q.size()), 64'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // reset state
    repeat (3) @(negedge i_ACLK);
    check("reset_outputs",
          64'({o_CMD_READY, o_RSP_VALID, o_M_AWVALID, o_M_WVALID, o_M_BREADY,
               o_M_ARVALID, o_M_RREADY}), 64'd0);
    check("reset_rsp_regs", 64'({o_RSP_RESP, o_RSP_RDATA}), 64'd0);
    check("reset_addr_data", 64'({o_M_AWADDR, o_M_WDATA}), 64'd0);
    i_ARESET = 0;
    @(negedge i_ACLK);
    check("cmd_ready_after_reset", 64'(o_CMD_READY), 64'd1);

    // 1: zero-wait write
    issue(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 3, 1, 0);
    drain();

    // 2: AW at +1, W at +4, EXOKAY
    w_delay = 3; cfg_bresp = 2'b01;
    issue(1, 32'h14, 32'hA5A5_0001, 4'h3, 32'h0, 2'b01, 6, 1, 0);
    drain();
    w_delay = 0; cfg_bresp = 2'b00;

    // 3: read with delayed ARREADY and RVALID
    ar_delay = 3; r_delay = 2; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
    issue(0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 8, 1, 0);
    drain();
    repeat (3) @(negedge i_ACLK);
    check("rsp_hold", 64'({o_RSP_RESP, o_RSP_RDATA}), 64'({2'b00, 32'h1234_5678}));
    ar_delay = 0; r_delay = 0;

    // 4: SLVERR read, then a normal write clears RDATA
    cfg_rdata = 32'hCAFE_0000; cfg_rresp = 2'b10;
    issue(0, 32'h44, 32'h0, 4'h0, 32'hCAFE_0000, 2'b10, 3, 1, 0);
    drain();
    cfg_rresp = 2'b00;
    issue(1, 32'h48, 32'h1122_3344, 4'hC, 32'h0, 2'b00, 3, 1, 0);
    drain();

    // 5: back-to-back write then read
    cfg_rdata = 32'h55AA_55AA;
    issue(1, 32'h50, 32'h0BAD_F00D, 4'hF, 32'h0, 2'b00, 3, 1, 0);
    issue(0, 32'h54, 32'h0, 4'h0, 32'h55AA_55AA, 2'b00, 3, 1, 1);
    drain();

    // 6: reset while waiting for B
    b_hold = 1;
    issue(1, 32'h60, 32'h7777_8888, 4'hF, 32'h0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 20 && !o_M_BREADY; k++) @(negedge i_ACLK);
    check("reached_wresp", 64'(o_M_BREADY), 64'd1);
    i_ARESET = 1;
    @(negedge i_ACLK);
    check("abort_outputs",
          64'({o_CMD_READY, o_RSP_VALID, o_M_AWVALID, o_M_WVALID, o_M_BREADY,
               o_M_ARVALID, o_M_RREADY}), 64'd0);
    @(negedge i_ACLK);
    i_ARESET = 0; b_hold = 0;
    @(negedge i_ACLK);
    check("cmd_ready_after_abort", 64'(o_CMD_READY), 64'd1);
    repeat (4) @(negedge i_ACLK);

    // normal operation after abort
    issue(1, 32'h64, 32'h0102_0304, 4'h5, 32'h0, 2'b00, 3, 1, 0);
    drain();
    check("payload_queues_empty", 64'(aw_q.size() + w_q.size() + ar_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
